// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore-style control unit for the multicycle MIPS datapath. Each instruction
//   is sequenced through fetch, decode, execute, memory and write-back states.
//   The unit drives the shared-ALU / shared-memory control lines. It also
//   handles memory wait states, flags unsupported opcodes and counts retired
//   instructions.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous, active-low reset
//   OP           opcode field from the instruction register
//   mem_ready    memory finished the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite
//                PC, memory and instruction-register strobes
//   BranchEQ, BranchNE
//                qualify PCWriteCond with ALU zero / not-zero
//   RegDst, MemtoReg, RegWrite, ALUSrcA, lui
//                register-file, ALU-A and LUI controls
//   ALUSrcB      00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp        111 R-type, 100 add, 101 or, 011 and, 010 sub, 000 lui pass
//   state        current state (debug)
//   instr_done   high on the final cycle of each legal instruction
//   illegal_op   one-cycle pulse in DECODE on an unsupported opcode
//   retired      count of completed instructions (wraps)
module multicycle_control #(
    parameter int RETIRE_WIDTH = 16,
    parameter int ALUOP_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              OP,
    input  logic                    mem_ready,
    output logic                    PCWrite,
    output logic                    PCWriteCond,
    output logic                    IorD,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    BranchEQ,
    output logic                    BranchNE,
    output logic                    RegDst,
    output logic                    MemtoReg,
    output logic                    RegWrite,
    output logic                    ALUSrcA,
    output logic                    lui,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              PCSource,
    output logic [ALUOP_WIDTH-1:0]  ALUOp,
    output logic [3:0]              state,
    output logic                    instr_done,
    output logic                    illegal_op,
    output logic [RETIRE_WIDTH-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ITYPE_WB = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] AOP_LUI = 3'b000;
    localparam logic [2:0] AOP_SUB = 3'b010;
    localparam logic [2:0] AOP_AND = 3'b011;
    localparam logic [2:0] AOP_ADD = 3'b100;
    localparam logic [2:0] AOP_OR  = 3'b101;
    localparam logic [2:0] AOP_R   = 3'b111;

    state_t     state_q;
    state_t     state_next;
    logic [5:0] op_q;
    logic [2:0] aluop_code;

    // ALU operation for the immediate-class instructions.
    // EXEC_I and ITYPE_WB share these values.
    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI: return AOP_AND;
            OP_ORI:  return AOP_OR;
            OP_LUI:  return AOP_LUI;
            default: return AOP_ADD;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // State, latched opcode and retirement counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
            retired <= '0;
        end else begin
            state_q <= state_next;
            if (state_q == S_DECODE)
                op_q <= OP;
            if (instr_done)
                retired <= retired + RETIRE_WIDTH'(1);
        end
    end

    // Next-state selection. DECODE dispatches on the live OP because op_q
    // only captures it at the end of that cycle.
    always_comb begin
        state_next = S_FETCH;
        case (state_q)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OP)
                    OP_LW, OP_SW:                    state_next = S_MEM_ADDR;
                    OP_R:                            state_next = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = S_EXEC_I;
                    OP_BEQ, OP_BNE:                  state_next = S_BRANCH;
                    OP_J:                            state_next = S_JUMP;
                    default:                         state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_next = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_next = S_RTYPE_WB;
            S_EXEC_I:   state_next = S_ITYPE_WB;
            default:    state_next = S_FETCH;
        endcase
    end

    // Control decode. Outputs depend on the registered state, plus mem_ready
    // in FETCH and MEM_WR. The whole decode is suppressed while reset is low,
    // so an aborted instruction never writes during the reset cycle.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        BranchEQ    = 1'b0;
        BranchNE    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        lui         = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        aluop_code  = 3'b000;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead    = 1'b1;
                    ALUSrcB    = 2'b01;
                    aluop_code = AOP_ADD;
                    IRWrite    = mem_ready;
                    PCWrite    = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    aluop_code = AOP_ADD;
                    illegal_op = !is_legal(OP);
                end
                S_MEM_ADDR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    aluop_code = AOP_ADD;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEM_WB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC_R: begin
                    ALUSrcA    = 1'b1;
                    aluop_code = AOP_R;
                end
                S_RTYPE_WB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    aluop_code = AOP_R;
                    instr_done = 1'b1;
                end
                S_EXEC_I, S_ITYPE_WB: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    aluop_code = imm_aluop(op_q);
                    lui        = (op_q == OP_LUI);
                    RegWrite   = (state_q == S_ITYPE_WB);
                    instr_done = (state_q == S_ITYPE_WB);
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = 2'b00;
                    aluop_code  = AOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchEQ    = (op_q == OP_BEQ);
                    BranchNE    = (op_q == OP_BNE);
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ALUOp = ALUOP_WIDTH'(aluop_code);
    assign state = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the MIPS datapath: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the shared-ALU / shared-memory datapath control lines. It keeps the single-cycle decoder's opcode set, ALUOp encoding and `lui` semantics, and adds BNE, LW, SW and J. It also adds memory wait-state handshaking, an illegal-opcode flag and a retired-instruction counter. It sits between the instruction register's opcode field and the multicycle datapath.

## Interface
- RETIRE_WIDTH, 16, width of the retired-instruction counter.
- ALUOP_WIDTH, 3, ALUOp width; must be ≥3; codes are zero-extended.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- OP  in  6  opcode field from the instruction register.
- mem_ready  in  1  memory completed the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  PC, memory and IR controls.
- BranchEQ, BranchNE  out  1 each  qualify PCWriteCond with ALU zero / not-zero.
- RegDst, MemtoReg, RegWrite, ALUSrcA, lui  out  1 each  register-file, ALU-A and LUI controls.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  out  ALUOP_WIDTH  111 R-type, 100 add, 101 or, 011 and, 010 sub, 000 lui pass.
- state  out  4  current state (debug).
- instr_done  out  1  high on the final cycle of each legal instruction.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- retired  out  RETIRE_WIDTH  count of completed instructions.

## Operation
- Opcodes: R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B.
- OP is latched into op_q on the DECODE cycle. All later states use op_q.
- Every output not listed for a state is 0.
- FETCH (0): MemRead=1, ALUSrcB=01, ALUOp=100.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE (1): ALUSrcB=11, ALUOp=100 (branch target into ALUOut). Next state:
  - LW/SW → MEM_ADDR.
  - R → EXEC_R.
  - ADDI/ANDI/ORI/LUI → EXEC_I.
  - BEQ/BNE → BRANCH.
  - J → JUMP.
  - Any other opcode → FETCH with illegal_op=1.
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=100. LW → MEM_RD; SW → MEM_WR.
- MEM_RD (3): IorD=1, MemRead=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB (4): MemtoReg=1, RegWrite=1, instr_done=1 → FETCH.
- MEM_WR (5): IorD=1, MemWrite=1. Hold until mem_ready; on mem_ready, instr_done=1 → FETCH.
- EXEC_R (6): ALUSrcA=1, ALUOp=111 → RTYPE_WB.
- RTYPE_WB (7): RegDst=1, RegWrite=1, ALUOp=111, instr_done=1 → FETCH.
- EXEC_I (8) and ITYPE_WB (9): ALUSrcA=1, ALUSrcB=10. Both states hold the same per-opcode values:
  - ADDI: ALUOp=100.
  - ANDI: ALUOp=011.
  - ORI: ALUOp=101.
  - LUI: ALUOp=000, lui=1.
  - ITYPE_WB additionally sets RegWrite=1 and instr_done=1, then → FETCH.
- BRANCH (10): ALUSrcA=1, ALUSrcB=00, ALUOp=010, PCWriteCond=1, PCSource=01. BranchEQ=(op_q==BEQ), BranchNE=(op_q==BNE). instr_done=1 → FETCH.
- JUMP (11): PCWrite=1, PCSource=10, instr_done=1 → FETCH.
- States 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- retired increments by 1 on every clock edge where instr_done=1. It wraps from all-ones to 0. Illegal opcodes do not count.

## Timing
- reset low at a rising edge: state ← FETCH, op_q ← 0, retired ← 0.
- While reset is low, every control output, instr_done and illegal_op is forced 0, independent of state.
- Reset low mid-instruction aborts the instruction. No write strobe is asserted in the reset cycle.
- Control outputs are Moore decodes of the registered state, plus mem_ready gating in FETCH and MEM_WR.
- Latency with mem_ready held high:
  - R, I-type, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle with mem_ready low in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Outputs stay constant during the wait.
- A mem_ready pulse outside FETCH, MEM_RD or MEM_WR is ignored.
- OP changing after DECODE has no effect on the current instruction.

## Test plan
- Reset low 2 cycles, then high: state=0, retired=0, all strobes 0 during reset. First cycle after release: MemRead=1, ALUSrcB=01.
- mem_ready=1, sequence R, ADDI, ORI, ANDI, LUI (OP valid in DECODE): states 0,1,6,7 then 0,1,8,9 ×4. ALUOp in the write-back states = 111,100,101,011,000; lui=1 only for LUI. retired=5 after 20 cycles.
- LW with mem_ready low for 3 cycles in MEM_RD: state 3 for 4 cycles, IorD=1 and MemRead=1 throughout, then MEM_WB with MemtoReg=1, RegWrite=1. Total 8 cycles.
- BEQ then BNE then J: BRANCH state has BranchEQ=1 (BEQ) then BranchNE=1 (BNE), both with PCWriteCond=1 and PCSource=01. JUMP has PCWrite=1 and PCSource=10. 9 cycles total, retired +3.
- OP=0x3F in DECODE: illegal_op=1 for one cycle, next state FETCH, retired unchanged, RegWrite and MemWrite never asserted.
- Preload retired to all-ones (RETIRE_WIDTH=4, 15 instructions), then one more instruction: retired=0. In a separate test, reset low during MEM_WR: MemWrite=0 that cycle and state=0 next.
